// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer.
// Function encodings, the reserved code and the request bundle.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  localparam logic [2:0] ALU_ILLEGAL = 3'b011;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [2:0]       f;
  } alu_req_t;

  function automatic logic is_illegal(input logic [2:0] f);
    return f == ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + ONE;
    end
    if (do_pop) begin
      rd_d = rd_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU requests, drives them onto a shared ALU from
// registers and returns each result on a valid/ready channel.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_z,
  output logic [2:0]       rsp_f,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  req_t             fifo_din;
  req_t             head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             full;
  logic             empty;

  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_f_q, alu_f_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_z_q, rsp_z_d;
  logic [2:0]       rsp_f_q, rsp_f_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign fifo_din  = '{a: req_a, b: req_b, f: req_f};
  assign req_ready = !full;
  assign fifo_push = req_valid && !full;

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_f_d     = alu_f_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_z_d     = rsp_z_q;
    rsp_f_d     = rsp_f_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (!empty) begin
          fifo_pop = 1'b1;
          alu_a_d  = head.a;
          alu_b_d  = head.b;
          alu_f_d  = head.f;
          state_d  = S_DRIVE;
        end
      end
      state_q == S_DRIVE: begin
        rsp_valid_d = 1'b1;
        rsp_f_d     = alu_f_q;
        rsp_err_d   = is_illegal(alu_f_q);
        rsp_y_d     = is_illegal(alu_f_q) ? '0 : alu_y;
        rsp_z_d     = is_illegal(alu_f_q) ? 1'b0 : alu_z;
        state_d     = S_RESP;
      end
      state_q == S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
          // Chain straight into the next op to keep 2 cycles/result
          if (!empty) begin
            fifo_pop = 1'b1;
            alu_a_d  = head.a;
            alu_b_d  = head.b;
            alu_f_d  = head.f;
            state_d  = S_DRIVE;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_f_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_z_q     <= 1'b0;
      rsp_f_q     <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_f_q     <= alu_f_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_z_q     <= rsp_z_d;
      rsp_f_q     <= rsp_f_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: two sequencers (16-bit and 2-bit counters)
// share one stimulus stream, each feeding its own ALU.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_f = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, req_ready2;
  logic [31:0] alu_a, alu_b, alu_y, alu_a2, alu_b2, alu_y2;
  logic [2:0]  alu_f, alu_f2;
  logic        alu_z, alu_z2;
  logic        rsp_valid, rsp_z, rsp_err;
  logic        rsp_valid2, rsp_z2, rsp_err2;
  logic [31:0] rsp_y, rsp_y2;
  logic [2:0]  rsp_f, rsp_f2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_f(req_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_f(rsp_f),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_op_sequencer #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_f(req_f),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_f(alu_f2),
    .alu_y(alu_y2), .alu_z(alu_z2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y2), .rsp_z(rsp_z2), .rsp_f(rsp_f2),
    .rsp_err(rsp_err2), .op_count(op_count2)
  );

  // Classic invert-B/carry-in ALU; reserved code yields junk
  function automatic logic [31:0] alu_eval(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic [31:0] bb;
    logic [31:0] s;
    bb = f[2] ? ~b : b;
    s  = a + bb + {31'b0, f[2]};
    case (f[1:0])
      2'b00:   return a & bb;
      2'b01:   return a | bb;
      2'b10:   return s;
      default: return f[2] ? {31'b0, ($signed(a) < $signed(b))}
                           : 32'hDEADBEEF;
    endcase
  endfunction

  always_comb begin
    alu_y  = alu_eval(alu_a, alu_b, alu_f);
    alu_z  = (alu_y == 32'd0);
    alu_y2 = alu_eval(alu_a2, alu_b2, alu_f2);
    alu_z2 = (alu_y2 == 32'd0);
  end

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic [2:0]  f;
    logic        err;
  } rsp_t;

  function automatic rsp_t model(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    rsp_t r;
    r.f = f;
    r.err = 1'b0;
    case (f)
      3'b000: r.y = a & b;
      3'b001: r.y = a | b;
      3'b010: r.y = a + b;
      3'b100: r.y = a & ~b;
      3'b101: r.y = a | ~b;
      3'b110: r.y = a - b;
      3'b111: r.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin r.y = 32'd0; r.err = 1'b1; end
    endcase
    r.z = !r.err && (r.y == 32'd0);
    return r;
  endfunction

  int   tests = 0;
  int   fails = 0;
  rsp_t exp_q[$];
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;
  int   rdy_mode = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic [31:0] p_y;
    logic        p_z, p_err;
    logic [2:0]  p_f;
    rsp_t        e;
    prev_stall = 1'b0;
    p_y = '0; p_z = 1'b0; p_err = 1'b0; p_f = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("op_count", 32'(op_count), 32'(exp_cnt));
      chk("op_count_sat", 32'(op_count2), 32'(exp_cnt2));
      if (prev_stall) begin
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_y", rsp_y, p_y);
        chk("stall_zfe", {27'b0, p_z, p_f, p_err},
            {27'b0, rsp_z, rsp_f, rsp_err});
      end
      if (req_valid && req_ready)
        exp_q.push_back(model(req_a, req_b, req_f));
      if (rsp_valid && exp_q.size() == 0)
        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      else if (rsp_valid && rsp_ready) begin
        e = exp_q.pop_front();
        chk("rsp_y", rsp_y, e.y);
        chk("rsp_z", 32'(rsp_z), 32'(e.z));
        chk("rsp_f", 32'(rsp_f), 32'(e.f));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      p_y = rsp_y; p_z = rsp_z; p_f = rsp_f; p_err = rsp_err;
    end
  end

  // Response-ready driver for toggling and random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) rsp_ready = ~rsp_ready;
      else if (rdy_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_a = a; req_b = b; req_f = f;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 500);
    if (!req_ready) chk("push_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra [5];
    logic [31:0] rb [5];
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    chk("rst_rsp", {26'b0, rsp_valid, rsp_z, rsp_err, rsp_f}, 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Single ADD with latency check
    rdy_mode = 0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    push(32'h0000_0001, 32'hFFFF_FFFF, 3'b010);
    @(negedge clk);
    chk("lat_t0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_t1_alu_a", alu_a, 32'h0000_0001);
    chk("lat_t1_alu_b", alu_b, 32'hFFFF_FFFF);
    chk("lat_t1_alu_f", 32'(alu_f), 32'd2);
    chk("lat_t1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2_valid", 32'(rsp_valid), 32'd1);
    chk("add_y", rsp_y, 32'h0000_0000);
    chk("add_z", 32'(rsp_z), 32'd1);
    @(negedge clk);
    chk("add_count", 32'(op_count), 32'd1);
    @(posedge clk); #1;

    // Fill the FIFO under backpressure
    rsp_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'h1234_5678, 3'b000);
    push(32'h1234_5678, 32'h8765_4321, 3'b001);
    push(32'h0000_0100, 32'h0000_0001, 3'b110);
    push(32'hFFFF_FFFF, 32'h0000_0000, 3'b111);
    push(32'h0000_0007, 32'h0000_0009, 3'b010);
    @(negedge clk);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Illegal code then SUB 1-1
    push(32'd5, 32'd5, 3'b011);
    push(32'd1, 32'd1, 3'b110);
    drain();

    // Toggling backpressure over 8 SLTs
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      push($urandom, $urandom, 3'b111);
    drain();
    rdy_mode = 0;
    rsp_ready = 1'b1;

    // Random mix with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      push($urandom, (i % 5 == 0) ? 32'd0 : $urandom,
           3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    drain();
    rdy_mode = 0;

    // Reset while an op is in DRIVE and three are queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      push(ra[i], rb[i], 3'b010);
    end
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("drive_alu_a", alu_a, ra[1]);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    exp_cnt2 = 0;
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_rsp", {26'b0, rsp_valid, rsp_z, rsp_err, rsp_f}, 32'd0);
    chk("arst_rsp_y", rsp_y, 32'd0);
    chk("arst_count", 32'(op_count), 32'd0);
    chk("arst_count2", 32'(op_count2), 32'd0);
    idle(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    idle(10);
    chk("post_rst_quiet", 32'(rsp_valid), 32'd0);
    push(32'h8000_0000, 32'h0000_0001, 3'b111);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
